// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder:
//   - dmem_state_e : responder state machine encoding
//   - DM_WORD_W    : data word width in bits
//   - DM_OFF_W     : number of byte-offset bits dropped from the address
//   - dm_cnt_width : wait-counter width for a given wait-state count
// ----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DM_WORD_W = 32;
    localparam int DM_OFF_W  = 2;

    typedef enum logic {
        DMEM_IDLE = 1'b0,
        DMEM_WAIT = 1'b1
    } dmem_state_e;

    // Counter must hold WAIT_CYCLES-1; keep at least one bit so the
    // zero-wait build still has a legal (unused) counter.
    function automatic int dm_cnt_width(input int wait_cycles);
        int w;
        w = (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// ----------------------------------------------------------------------------
// dmem_array
// Single-port synchronous word RAM, one-cycle read latency, no reset.
// Ports:
//   clk_i  : clock, rising edge
//   en     : access enable
//   we     : 1 = write wdata to idx, 0 = read idx into rdata
//   idx    : word index
//   wdata  : write data
//   rdata  : read data, valid the cycle after a read access; held otherwise
// ----------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_W = 10
) (
    input  logic                 clk_i,
    input  logic                 en,
    input  logic                 we,
    input  logic [DEPTH_W-1:0]   idx,
    input  logic [DM_WORD_W-1:0] wdata,
    output logic [DM_WORD_W-1:0] rdata
);

    logic [DM_WORD_W-1:0] mem_q [2**DEPTH_W];
    logic [DM_WORD_W-1:0] rdata_q;

    // Storage write and registered read port; writes leave rdata untouched.
    always_ff @(posedge clk_i) begin
        if (en) begin
            if (we) begin
                mem_q[idx] <= wdata;
            end else begin
                rdata_q <= mem_q[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Terminates the data-cache memory port. Accepts word read/write requests,
// inserts WAIT_CYCLES busy cycles per access, then executes it against a
// single-port word RAM. Read data is registered and held until the next read.
// Ports:
//   clk_i       : clock, rising edge
//   rst_i       : asynchronous active-high reset
//   dm_en_i     : request valid
//   dm_wen_i    : 1 = write, 0 = read
//   dm_addr_i   : byte address (bits [1:0] and above the array range ignored)
//   dm_din_i    : write data
//   dm_busy_o   : responder busy, requests ignored while high
//   dm_dout_o   : read data, held until the next read completes
//   dm_rvalid_o : one-cycle pulse when dm_dout_o was updated
// ----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_W     = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dm_en_i,
    input  logic                 dm_wen_i,
    input  logic [31:0]          dm_addr_i,
    input  logic [DM_WORD_W-1:0] dm_din_i,
    output logic                 dm_busy_o,
    output logic [DM_WORD_W-1:0] dm_dout_o,
    output logic                 dm_rvalid_o
);

    localparam int CNT_W  = dm_cnt_width(WAIT_CYCLES);
    localparam int IDX_HI = DEPTH_W + DM_OFF_W - 1;

    dmem_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic [DM_WORD_W-1:0] dout_q, dout_d;
    logic                 rvalid_q, rvalid_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 req_wen_q, req_wen_d;
    logic [DEPTH_W-1:0]   req_idx_q, req_idx_d;
    logic [DM_WORD_W-1:0] req_din_q, req_din_d;

    logic                 accept_s;
    logic [DEPTH_W-1:0]   in_idx_s;
    logic                 ram_en_s;
    logic                 ram_we_s;
    logic [DEPTH_W-1:0]   ram_idx_s;
    logic [DM_WORD_W-1:0] ram_wdata_s;
    logic [DM_WORD_W-1:0] ram_rdata_s;

    // Address bits outside the word index alias away by design.
    logic unused_addr_s;
    assign unused_addr_s = ^{dm_addr_i[31:IDX_HI+1], dm_addr_i[DM_OFF_W-1:0]};

    assign accept_s = dm_en_i & ~busy_q;
    assign in_idx_s = dm_addr_i[IDX_HI:DM_OFF_W];

    // Next-state, request latch and RAM port control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        req_wen_d   = req_wen_q;
        req_idx_d   = req_idx_q;
        req_din_d   = req_din_q;
        rd_pend_d   = 1'b0;
        // RAM read issued on the execute edge lands in dout one edge later.
        rvalid_d    = rd_pend_q;
        dout_d      = rd_pend_q ? ram_rdata_s : dout_q;
        ram_en_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_idx_s   = req_idx_q;
        ram_wdata_s = req_din_q;

        if (WAIT_CYCLES == 0) begin
            // Zero-wait: execute straight from the inputs on the accept edge.
            state_d     = DMEM_IDLE;
            busy_d      = 1'b0;
            ram_en_s    = accept_s;
            ram_we_s    = dm_wen_i;
            ram_idx_s   = in_idx_s;
            ram_wdata_s = dm_din_i;
            rd_pend_d   = accept_s & ~dm_wen_i;
        end else begin
            case (state_q)
                DMEM_IDLE: begin
                    if (accept_s) begin
                        req_wen_d = dm_wen_i;
                        req_idx_d = in_idx_s;
                        req_din_d = dm_din_i;
                        cnt_d     = CNT_W'(WAIT_CYCLES - 1);
                        busy_d    = 1'b1;
                        state_d   = DMEM_WAIT;
                    end else begin
                        busy_d    = 1'b0;
                    end
                end
                DMEM_WAIT: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        ram_en_s  = 1'b1;
                        ram_we_s  = req_wen_q;
                        rd_pend_d = ~req_wen_q;
                        busy_d    = 1'b0;
                        state_d   = DMEM_IDLE;
                    end else begin
                        cnt_d     = cnt_q - CNT_W'(1);
                        busy_d    = 1'b1;
                    end
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = DMEM_IDLE;
                end
            endcase
        end
    end

    // State machine, counter, request latch and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= DMEM_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            busy_q    <= 1'b0;
            dout_q    <= {DM_WORD_W{1'b0}};
            rvalid_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            req_wen_q <= 1'b0;
            req_idx_q <= {DEPTH_W{1'b0}};
            req_din_q <= {DM_WORD_W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            dout_q    <= dout_d;
            rvalid_q  <= rvalid_d;
            rd_pend_q <= rd_pend_d;
            req_wen_q <= req_wen_d;
            req_idx_q <= req_idx_d;
            req_din_q <= req_din_d;
        end
    end

    dmem_array #(
        .DEPTH_W (DEPTH_W)
    ) u_array (
        .clk_i (clk_i),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .idx   (ram_idx_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign dm_busy_o   = busy_q;
    assign dm_dout_o   = dout_q;
    assign dm_rvalid_o = rvalid_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        rst;

    logic        en2, wen2;
    logic [31:0] addr2, din2;
    logic        busy2, rv2;
    logic [31:0] dout2;

    logic        en0, wen0;
    logic [31:0] addr0, din0;
    logic        busy0, rv0;
    logic [31:0] dout0;

    int tests_run    = 0;
    int tests_failed = 0;

    dmem_responder #(.DEPTH_W(10), .WAIT_CYCLES(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .dm_en_i     (en2),
        .dm_wen_i    (wen2),
        .dm_addr_i   (addr2),
        .dm_din_i    (din2),
        .dm_busy_o   (busy2),
        .dm_dout_o   (dout2),
        .dm_rvalid_o (rv2)
    );

    dmem_responder #(.DEPTH_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .dm_en_i     (en0),
        .dm_wen_i    (wen0),
        .dm_addr_i   (addr0),
        .dm_din_i    (din0),
        .dm_busy_o   (busy0),
        .dm_dout_o   (dout0),
        .dm_rvalid_o (rv0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write on the 2-wait DUT; called at posedge+1 with busy low.
    task automatic write2(input logic [31:0] a, input logic [31:0] d, input string nm);
        en2 = 1'b1; wen2 = 1'b1; addr2 = a; din2 = d;
        @(posedge clk); #1;
        en2 = 1'b0;
        tests_run++;
        if (busy2 !== 1'b1) begin tests_failed++; $display("FAIL %s busy_c1: got %0b want 1", nm, busy2); end
        @(posedge clk); #1;
        tests_run++;
        if (busy2 !== 1'b1) begin tests_failed++; $display("FAIL %s busy_c2: got %0b want 1", nm, busy2); end
        @(posedge clk); #1;
        tests_run++;
        if (busy2 !== 1'b0) begin tests_failed++; $display("FAIL %s busy_c3: got %0b want 0", nm, busy2); end
        @(posedge clk); #1;
        tests_run++;
        if (rv2 !== 1'b0) begin tests_failed++; $display("FAIL %s wr_rvalid: got %0b want 0", nm, rv2); end
    endtask

    // Read on the 2-wait DUT; data expected with rvalid on edge 3 after accept.
    task automatic read2(input logic [31:0] a, input logic [31:0] exp, input string nm);
        en2 = 1'b1; wen2 = 1'b0; addr2 = a; din2 = 32'h0;
        @(posedge clk); #1;
        en2 = 1'b0;
        tests_run++;
        if (busy2 !== 1'b1) begin tests_failed++; $display("FAIL %s busy_c1: got %0b want 1", nm, busy2); end
        @(posedge clk); #1;
        tests_run++;
        if (busy2 !== 1'b1) begin tests_failed++; $display("FAIL %s busy_c2: got %0b want 1", nm, busy2); end
        @(posedge clk); #1;
        tests_run++;
        if (busy2 !== 1'b0 || rv2 !== 1'b0) begin
            tests_failed++; $display("FAIL %s edge2: busy %0b rvalid %0b want 0 0", nm, busy2, rv2);
        end
        @(posedge clk); #1;
        tests_run++;
        if (rv2 !== 1'b1 || dout2 !== exp) begin
            tests_failed++; $display("FAIL %s data: rvalid %0b dout %h want 1 %h", nm, rv2, dout2, exp);
        end
        @(posedge clk); #1;
        tests_run++;
        if (rv2 !== 1'b0 || dout2 !== exp) begin
            tests_failed++; $display("FAIL %s hold: rvalid %0b dout %h want 0 %h", nm, rv2, dout2, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en2 = 1'b0; wen2 = 1'b0; addr2 = 32'h0; din2 = 32'h0;
        en0 = 1'b0; wen0 = 1'b0; addr0 = 32'h0; din0 = 32'h0;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (busy2 !== 1'b0 || dout2 !== 32'h0 || rv2 !== 1'b0) begin
            tests_failed++; $display("FAIL reset_async w2: busy %0b dout %h rv %0b want 0 0 0", busy2, dout2, rv2);
        end
        tests_run++;
        if (busy0 !== 1'b0 || dout0 !== 32'h0 || rv0 !== 1'b0) begin
            tests_failed++; $display("FAIL reset_async w0: busy %0b dout %h rv %0b want 0 0 0", busy0, dout0, rv0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (busy2 !== 1'b0 || rv2 !== 1'b0 || rv0 !== 1'b0 || busy0 !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_quiet: busy2 %0b rv2 %0b busy0 %0b rv0 %0b want all 0", busy2, rv2, busy0, rv0);
            end
        end
    endtask

    task automatic test_wait2_rw();
        write2(32'h10, 32'hDEADBEEF, "w2_write");
        read2(32'h10, 32'hDEADBEEF, "w2_read");
    endtask

    task automatic test_alias();
        write2(32'h1004, 32'h12345678, "alias_write");
        read2(32'h0004, 32'h12345678, "alias_rd4");
        read2(32'h0006, 32'h12345678, "alias_rd6");
    endtask

    task automatic test_busy_ignore();
        write2(32'h20, 32'h20202020, "ign_setup");
        en2 = 1'b1; wen2 = 1'b0; addr2 = 32'h10; din2 = 32'h0;
        @(posedge clk); #1;
        // stray write while busy
        en2 = 1'b1; wen2 = 1'b1; addr2 = 32'h20; din2 = 32'hBADBAD00;
        tests_run++;
        if (busy2 !== 1'b1) begin tests_failed++; $display("FAIL ign_busy1: got %0b want 1", busy2); end
        @(posedge clk); #1;
        en2 = 1'b0;
        tests_run++;
        if (busy2 !== 1'b1) begin tests_failed++; $display("FAIL ign_busy2: got %0b want 1", busy2); end
        @(posedge clk); #1;
        tests_run++;
        if (busy2 !== 1'b0) begin tests_failed++; $display("FAIL ign_busy3: got %0b want 0", busy2); end
        @(posedge clk); #1;
        tests_run++;
        if (rv2 !== 1'b1 || dout2 !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL ign_orig_read: rvalid %0b dout %h want 1 deadbeef", rv2, dout2);
        end
        read2(32'h20, 32'h20202020, "ign_word20");
    endtask

    task automatic test_wait0_stream();
        logic [31:0] wa [3];
        logic [31:0] wd [3];
        wa[0] = 32'h0; wa[1] = 32'h4; wa[2] = 32'h8;
        wd[0] = 32'h11110000; wd[1] = 32'h22220004; wd[2] = 32'h33330008;
        for (int i = 0; i < 3; i++) begin
            en0 = 1'b1; wen0 = 1'b1; addr0 = wa[i]; din0 = wd[i];
            @(posedge clk); #1;
            tests_run++;
            if (busy0 !== 1'b0 || rv0 !== 1'b0) begin
                tests_failed++; $display("FAIL w0_write%0d: busy %0b rvalid %0b want 0 0", i, busy0, rv0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                en0 = 1'b1; wen0 = 1'b0; addr0 = wa[i];
            end else begin
                en0 = 1'b0;
            end
            @(posedge clk); #1;
            if (i > 0) begin
                tests_run++;
                if (busy0 !== 1'b0 || rv0 !== 1'b1 || dout0 !== wd[i-1]) begin
                    tests_failed++;
                    $display("FAIL w0_read%0d: busy %0b rvalid %0b dout %h want 0 1 %h", i-1, busy0, rv0, dout0, wd[i-1]);
                end
            end else begin
                tests_run++;
                if (busy0 !== 1'b0 || rv0 !== 1'b0) begin
                    tests_failed++; $display("FAIL w0_read_lat: busy %0b rvalid %0b want 0 0", busy0, rv0);
                end
            end
        end
        @(posedge clk); #1;
        tests_run++;
        if (rv0 !== 1'b0 || dout0 !== wd[2]) begin
            tests_failed++; $display("FAIL w0_hold: rvalid %0b dout %h want 0 %h", rv0, dout0, wd[2]);
        end
    endtask

    task automatic test_reset_mid_write();
        write2(32'h40, 32'h00000001, "rst_setup");
        en2 = 1'b1; wen2 = 1'b1; addr2 = 32'h40; din2 = 32'hFFFF0000;
        @(posedge clk); #1;
        en2 = 1'b0;
        tests_run++;
        if (busy2 !== 1'b1) begin tests_failed++; $display("FAIL rst_wait_busy: got %0b want 1", busy2); end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (busy2 !== 1'b0 || dout2 !== 32'h0 || rv2 !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid: busy %0b dout %h rv %0b want 0 0 0", busy2, dout2, rv2);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        read2(32'h40, 32'h00000001, "rst_no_commit");
    endtask

    initial begin
        test_reset();
        test_wait2_rw();
        test_alias();
        test_busy_ignore();
        test_wait0_stream();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
